// File: rtl/minimig_autoconfig_pkg.sv
// Shared types and constants for the Minimig AutoConfig chain sequencer:
// FSM states, board slot numbers, register offsets and RAM size-nybble codes.
package minimig_autoconfig_pkg;

    typedef enum logic [3:0] {
        S_INIT0,
        S_INIT1,
        S_INIT2,
        S_SELECT,
        S_IDLE,
        S_RD1,
        S_RD2,
        S_RD3,
        S_ACK,
        S_DONE
    } state_t;

    localparam logic [1:0] SLOT_Z2  = 2'd0;
    localparam logic [1:0] SLOT_Z3A = 2'd1;
    localparam logic [1:0] SLOT_Z3B = 2'd2;
    localparam logic [1:0] SLOT_ETH = 2'd3;

    localparam logic [5:0] REG_Z3BASE = 6'h22;
    localparam logic [5:0] REG_Z2BASE = 6'h24;
    localparam logic [5:0] REG_SHUTUP = 6'h26;

    localparam logic [3:0] SZ_2MB  = 4'b0110;
    localparam logic [3:0] SZ_4MB  = 4'b0111;
    localparam logic [3:0] SZ_8MB  = 4'b0000;
    localparam logic [3:0] SZ_NONE = 4'b1111;

    // Nybble RAM locations holding the size fields patched after reset.
    localparam logic [8:0] ROM_Z2_SIZE   = 9'h001;
    localparam logic [8:0] ROM_Z3B_SIZE0 = 9'h081;
    localparam logic [8:0] ROM_Z3B_SIZE1 = 9'h085;

    // Maps a 2-bit board size selector to its AutoConfig size nybble.
    function automatic logic [3:0] size_code(input logic [1:0] sz, input logic allow_8mb);
        case (sz)
            2'b01:   size_code = SZ_2MB;
            2'b10:   size_code = SZ_4MB;
            2'b11:   size_code = allow_8mb ? SZ_8MB : SZ_NONE;
            default: size_code = SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/minimig_autoconfig_ctrl.sv
// Zorro AutoConfig chain sequencer: patches board size nybbles after reset,
// serves $E8xxxx reads from the nybble RAM and latches base-address writes.
module minimig_autoconfig_ctrl
    import minimig_autoconfig_pkg::*;
#(
    parameter int SLOT_BITS = 2,
    parameter int REG_BITS  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    fastram_sz,
    input  logic [1:0]                    bank0_sz,
    input  logic                          z3_en,
    input  logic                          eth_en,
    input  logic                          req,
    input  logic                          we,
    input  logic [REG_BITS-1:0]           addr,
    input  logic [15:0]                   din,
    output logic [15:0]                   dout,
    output logic                          ack,
    output logic [SLOT_BITS+REG_BITS:0]   rom_a_read,
    output logic [SLOT_BITS+REG_BITS:0]   rom_a_write,
    output logic [3:0]                    rom_d,
    output logic                          rom_we,
    input  logic [3:0]                    rom_q,
    output logic [7:0]                    z2_base,
    output logic [15:0]                   z3a_base,
    output logic [15:0]                   z3b_base,
    output logic [15:0]                   eth_base,
    output logic                          z2_cfg,
    output logic                          z3a_cfg,
    output logic                          z3b_cfg,
    output logic                          eth_cfg,
    output logic                          cfg_done
);

    localparam int AW = SLOT_BITS + REG_BITS + 1;

    state_t                 r_state, w_state_nxt;
    state_t                 r_ret, w_ret_nxt;
    logic [SLOT_BITS-1:0]   r_slot, w_slot_nxt;
    logic [AW-1:0]          r_rom_a_read;
    logic [AW-1:0]          r_rom_a_write, w_rom_a_write;
    logic [3:0]             r_rom_d, w_rom_d;
    logic                   r_rom_we, w_rom_we;
    logic [15:0]            r_dout;
    logic                   r_ack, w_ack_nxt;
    logic [7:0]             r_z2_base;
    logic [15:0]            r_z3a_base, r_z3b_base, r_eth_base;
    logic [3:0]             r_cfg;
    logic                   r_cfg_done;

    logic [3:0]             w_slot_en;
    logic                   w_rd_accept, w_wr_accept, w_done_accept;
    logic                   w_z2_hit, w_z3_hit, w_shutup, w_wr_advance;

    assign w_slot_en = {eth_en, (bank0_sz == 2'b01) || (bank0_sz == 2'b10), z3_en, fastram_sz != 2'b00};

    assign w_z2_hit     = (r_slot == SLOT_Z2) && (addr == REG_Z2BASE);
    assign w_z3_hit     = (r_slot != SLOT_Z2) && (addr == REG_Z3BASE);
    assign w_shutup     = (addr == REG_SHUTUP);
    assign w_wr_advance = w_z2_hit || w_z3_hit || w_shutup;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
        w_state_nxt   = r_state;
        w_ret_nxt     = r_ret;
        w_slot_nxt    = r_slot;
        w_rd_accept   = 1'b0;
        w_wr_accept   = 1'b0;
        w_done_accept = 1'b0;
        w_rom_we      = 1'b0;
        w_rom_a_write = '0;
        w_rom_d       = '0;
        case (r_state)
            S_INIT0: begin
                w_rom_we      = 1'b1;
                w_rom_a_write = ROM_Z2_SIZE;
                w_rom_d       = size_code(fastram_sz, 1'b1);
                w_state_nxt   = S_INIT1;
            end
            S_INIT1: begin
                w_rom_we      = 1'b1;
                w_rom_a_write = ROM_Z3B_SIZE0;
                w_rom_d       = size_code(bank0_sz, 1'b0);
                w_state_nxt   = S_INIT2;
            end
            S_INIT2: begin
                w_rom_we      = 1'b1;
                w_rom_a_write = ROM_Z3B_SIZE1;
                w_rom_d       = size_code(bank0_sz, 1'b0);
                w_state_nxt   = S_SELECT;
            end
            S_SELECT: begin
                if (w_slot_en[r_slot])
                    w_state_nxt = S_IDLE;
                else if (r_slot == SLOT_ETH)
                    w_state_nxt = S_DONE;
                else
                    w_slot_nxt = r_slot + 1'b1;
            end
            S_IDLE: begin
                if (req && !we) begin
                    w_rd_accept = 1'b1;
                    w_ret_nxt   = S_IDLE;
                    w_state_nxt = S_RD1;
                end else if (req) begin
                    w_wr_accept = 1'b1;
                    w_ret_nxt   = S_IDLE;
                    w_state_nxt = S_ACK;
                    if (w_wr_advance) begin
                        if (r_slot == SLOT_ETH) begin
                            w_ret_nxt = S_DONE;
                        end else begin
                            w_slot_nxt = r_slot + 1'b1;
                            w_ret_nxt  = S_SELECT;
                        end
                    end
                end
            end
            S_RD1: w_state_nxt = S_RD2;
            S_RD2: w_state_nxt = S_RD3;
            S_RD3: w_state_nxt = S_ACK;
            S_ACK: begin
                if (!req)
                    w_state_nxt = r_ret;
            end
            S_DONE: begin
                if (req) begin
                    w_done_accept = 1'b1;
                    w_ret_nxt     = S_DONE;
                    w_state_nxt   = S_ACK;
                end
            end
            default: w_state_nxt = S_INIT0;
        endcase
    end

    // ack pulses only on entry to ACK, so a req held high afterwards is not re-acknowledged.
    assign w_ack_nxt = (w_state_nxt == S_ACK) && (r_state != S_ACK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_INIT0;
            r_ret         <= S_IDLE;
            r_slot        <= '0;
            r_ack         <= 1'b0;
            r_rom_we      <= 1'b0;
            r_rom_a_write <= '0;
            r_rom_d       <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
            r_state       <= w_state_nxt;
            r_ret         <= w_ret_nxt;
            r_slot        <= w_slot_nxt;
            r_ack         <= w_ack_nxt;
            r_rom_we      <= w_rom_we;
            r_rom_a_write <= w_rom_a_write;
            r_rom_d       <= w_rom_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rom_a_read <= '0;
            r_dout       <= 16'hFFFF;
            r_z2_base    <= '0;
            r_z3a_base   <= '0;
            r_z3b_base   <= '0;
            r_eth_base   <= '0;
            r_cfg        <= '0;
            r_cfg_done   <= 1'b0;
        end else begin
            if (w_rd_accept)
                r_rom_a_read <= {1'b0, r_slot, addr};
            if (r_state == S_RD3)
                r_dout <= {rom_q, 12'hFFF};
            if (w_done_accept && !we)
                r_dout <= 16'hFFFF;
            if (w_wr_accept && w_z2_hit) begin
                r_z2_base      <= din[15:8];
                r_cfg[SLOT_Z2] <= 1'b1;
            end
            if (w_wr_accept && w_z3_hit) begin
                case (r_slot)
                    SLOT_Z3A: begin r_z3a_base <= din; r_cfg[SLOT_Z3A] <= 1'b1; end
                    SLOT_Z3B: begin r_z3b_base <= din; r_cfg[SLOT_Z3B] <= 1'b1; end
                    default:  begin r_eth_base <= din; r_cfg[SLOT_ETH] <= 1'b1; end
                endcase
            end
            if (w_state_nxt == S_DONE)
                r_cfg_done <= 1'b1;
        end
    end

    assign dout        = r_dout;
    assign ack         = r_ack;
    assign rom_a_read  = r_rom_a_read;
    assign rom_a_write = r_rom_a_write;
    assign rom_d       = r_rom_d;
    assign rom_we      = r_rom_we;
    assign z2_base     = r_z2_base;
    assign z3a_base    = r_z3a_base;
    assign z3b_base    = r_z3b_base;
    assign eth_base    = r_eth_base;
    assign z2_cfg      = r_cfg[SLOT_Z2];
    assign z3a_cfg     = r_cfg[SLOT_Z3A];
    assign z3b_cfg     = r_cfg[SLOT_Z3B];
    assign eth_cfg     = r_cfg[SLOT_ETH];
    assign cfg_done    = r_cfg_done;

endmodule

// File: tb/tb_minimig_autoconfig_ctrl.sv
// Directed bench for minimig_autoconfig_ctrl with a 2-clock-latency nybble RAM model.
module tb_minimig_autoconfig_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  fastram_sz = 2'b00;
    logic [1:0]  bank0_sz = 2'b00;
    logic        z3_en = 1'b0;
    logic        eth_en = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [5:0]  addr = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        ack;
    logic [8:0]  rom_a_read, rom_a_write;
    logic [3:0]  rom_d, rom_q;
    logic        rom_we;
    logic [7:0]  z2_base;
    logic [15:0] z3a_base, z3b_base, eth_base;
    logic        z2_cfg, z3a_cfg, z3b_cfg, eth_cfg, cfg_done;

    int passes = 0;
    int checks = 0;
    int ack_pulses = 0;
    int lat;
    int p0;

    always #5 clk = ~clk;

    minimig_autoconfig_ctrl dut (
        .clk(clk), .reset(reset), .fastram_sz(fastram_sz), .bank0_sz(bank0_sz),
        .z3_en(z3_en), .eth_en(eth_en), .req(req), .we(we), .addr(addr), .din(din),
        .dout(dout), .ack(ack), .rom_a_read(rom_a_read), .rom_a_write(rom_a_write),
        .rom_d(rom_d), .rom_we(rom_we), .rom_q(rom_q), .z2_base(z2_base),
        .z3a_base(z3a_base), .z3b_base(z3b_base), .eth_base(eth_base),
        .z2_cfg(z2_cfg), .z3a_cfg(z3a_cfg), .z3b_cfg(z3b_cfg), .eth_cfg(eth_cfg),
        .cfg_done(cfg_done)
    );

    // Nybble RAM model: preset contents, synchronous write, two-register read pipe.
    logic [3:0] mem [0:511];
    logic [3:0] q_pipe;
    logic       preload = 1'b1;

    function automatic logic [3:0] init_val(input int i);
        case (i)
            'h040:   init_val = 4'hA;
            'h080:   init_val = 4'h9;
            'h0C0:   init_val = 4'h8;
            default: init_val = 4'h5;
        endcase
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
            preload <= 1'b0;
        end else if (rom_we) begin
            mem[rom_a_write] <= rom_d;
        end
        q_pipe <= mem[rom_a_read];
        rom_q  <= q_pipe;
    end

    always @(negedge clk) if (ack) ack_pulses <= ack_pulses + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dout"}, dout, 16'hFFFF);
        check({tag, "_flags"}, {ack, rom_we, z2_cfg, z3a_cfg, z3b_cfg, eth_cfg, cfg_done}, 0);
        check({tag, "_bases"}, {z2_base, z3a_base, z3b_base, eth_base}, 0);
        check({tag, "_rda"}, rom_a_read, 0);
    endtask

    // Waits for the three size-nybble writes and checks them cycle by cycle.
    task automatic check_init(input logic [3:0] d_z2, input logic [3:0] d_b0);
        int n = 0;
        do begin @(negedge clk); n++; end while (!rom_we && n < 10);
        check("init_w1", {rom_we, rom_a_write, rom_d}, {1'b1, 9'h001, d_z2});
        @(negedge clk);
        check("init_w2", {rom_we, rom_a_write, rom_d}, {1'b1, 9'h081, d_b0});
        @(negedge clk);
        check("init_w3", {rom_we, rom_a_write, rom_d}, {1'b1, 9'h085, d_b0});
        @(negedge clk);
        check("init_we_off", rom_we, 1'b0);
    endtask

    // One CPU access; lat = clock cycles from req until ack is seen.
    task automatic access(input logic w, input logic [5:0] a, input logic [15:0] d,
                          input int hold, output int l);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; din = d;
        l = 0;
        do begin @(negedge clk); l++; end while (!ack && l < 20);
        check("ack_seen", ack, 1'b1);
        repeat (hold) @(negedge clk);
        req = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
    endtask

    initial begin
        // Scenario A: 8MB Z2, 4MB bank0, Z3 and Ethernet enabled.
        fastram_sz = 2'b11; bank0_sz = 2'b10; z3_en = 1'b1; eth_en = 1'b1;
        apply_reset();
        check_init(4'b0000, 4'b0111);

        access(1'b0, 6'h01, 16'h0, 0, lat);
        check("a_rd_lat", lat, 4);
        check("a_rd_z2size", dout, 16'h0FFF);

        access(1'b1, 6'h24, 16'h2000, 0, lat);
        check("a_z2_wr_lat", lat, 1);
        check("a_z2_base", {z2_cfg, z2_base}, {1'b1, 8'h20});

        access(1'b0, 6'h00, 16'h0, 0, lat);
        check("a_rd_slot1", dout, 16'hAFFF);

        access(1'b1, 6'h26, 16'h0, 0, lat);
        check("a_shutup_lat", lat, 1);
        check("a_shutup_flags", {z3a_cfg, z3b_cfg, eth_cfg, cfg_done}, 0);

        access(1'b0, 6'h00, 16'h0, 0, lat);
        check("a_rd_slot2", dout, 16'h9FFF);
        access(1'b0, 6'h01, 16'h0, 0, lat);
        check("a_rd_slot2_size", dout, 16'h7FFF);

        access(1'b1, 6'h22, 16'h4000, 0, lat);
        check("a_z3b_base", {z3b_cfg, z3b_base, z3a_base}, {1'b1, 16'h4000, 16'h0000});

        access(1'b1, 6'h25, 16'h1234, 0, lat);
        check("a_ignored_wr", {eth_cfg, eth_base, cfg_done}, 0);

        p0 = ack_pulses;
        access(1'b0, 6'h00, 16'h0, 10, lat);
        check("a_rd_slot3", dout, 16'h8FFF);
        check("a_held_one_ack", ack_pulses, p0 + 1);
        access(1'b0, 6'h00, 16'h0, 0, lat);
        check("a_second_ack", ack_pulses, p0 + 2);

        access(1'b1, 6'h22, 16'h4010, 0, lat);
        check("a_eth_base", {eth_cfg, eth_base}, {1'b1, 16'h4010});
        check("a_cfg_done", cfg_done, 1'b1);

        access(1'b0, 6'h01, 16'h0, 0, lat);
        check("a_done_rd_lat", lat, 1);
        check("a_done_rd", dout, 16'hFFFF);
        access(1'b1, 6'h24, 16'hAB00, 0, lat);
        check("a_done_wr", {z2_cfg, z2_base, cfg_done}, {1'b1, 8'h20, 1'b1});

        // Scenario B: only Ethernet enabled; chain must skip slots 0..2.
        fastram_sz = 2'b00; bank0_sz = 2'b00; z3_en = 1'b0; eth_en = 1'b1;
        apply_reset();
        check_init(4'b1111, 4'b1111);
        repeat (6) @(negedge clk);
        access(1'b0, 6'h00, 16'h0, 0, lat);
        check("b_rd_slot3", dout, 16'h8FFF);
        access(1'b1, 6'h22, 16'h4010, 0, lat);
        check("b_eth_base", {eth_cfg, eth_base, z2_cfg, z3a_cfg, z3b_cfg}, {1'b1, 16'h4010, 3'b000});
        check("b_cfg_done", cfg_done, 1'b1);
        access(1'b0, 6'h00, 16'h0, 0, lat);
        check("b_done_rd", dout, 16'hFFFF);

        // Scenario C: reset while a read sits in RD2.
        fastram_sz = 2'b11; bank0_sz = 2'b10; z3_en = 1'b1; eth_en = 1'b1;
        apply_reset();
        check_init(4'b0000, 4'b0111);
        access(1'b1, 6'h24, 16'h5500, 0, lat);
        check("c_z2_base", {z2_cfg, z2_base}, {1'b1, 8'h55});
        p0 = ack_pulses;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 6'h00;
        repeat (2) @(negedge clk);
        check("c_rd2_no_ack", ack, 1'b0);
        reset = 1'b1;
        #1;
        req = 1'b0;
        check_reset_vals("c_midrst");
        repeat (3) @(negedge clk);
        check("c_no_ack_pulse", ack_pulses, p0);
        reset = 1'b0;
        check_init(4'b0000, 4'b0111);
        access(1'b0, 6'h01, 16'h0, 0, lat);
        check("c_rd_after_rst", {lat[7:0], dout, z2_cfg}, {8'd4, 16'h0FFF, 1'b0});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/minimig_autoconfig_ctrl.md
Name: minimig_autoconfig_ctrl

Overview:
Sequences the Zorro AutoConfig chain for the four on-chip boards held in the 512x4 autoconfig nybble RAM: slot 0 Z2 Fast RAM, slot 1 Z3 Fast RAM, slot 2 Z3 spare bank-0 RAM, slot 3 Ethernet.
- After reset, patches the size nybbles through the RAM write port.
- Serves CPU reads from the $E8xxxx window via the RAM read port.
- Decodes base-address and shut-up writes, advances past configured or disabled slots, and publishes per-board base addresses and configured flags to the address decoders.

Parameters:
SLOT_BITS, 2, board slot index width (slot = rom address bits [7:6])
REG_BITS, 6, register index width per slot (CPU offset bits [6:1])

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
fastram_sz  in  2  Z2 size: 00 none, 01 2MB, 10 4MB, 11 8MB
bank0_sz  in  2  spare bank-0 size: 00 none, 01 2MB, 10 4MB, 11 reserved (treated as none)
z3_en  in  1  enable slot 1
eth_en  in  1  enable slot 3
req  in  1  CPU access request in autoconfig window, held until ack
we  in  1  1 = write, 0 = read; valid with req
addr  in  6  CPU byte offset bits [6:1]
din  in  16  CPU write data
dout  out  16  read data, {nybble, 12'hFFF}
ack  out  1  one-cycle completion pulse
rom_a_read  out  9  to autoconfig RAM read address
rom_a_write  out  9  to autoconfig RAM write address
rom_d  out  4  to autoconfig RAM write data
rom_we  out  1  to autoconfig RAM write enable
rom_q  in  4  from autoconfig RAM, valid 2 clocks after rom_a_read changes
z2_base  out  8  Z2 base A23..A16
z3a_base  out  16  slot 1 base A31..A16
z3b_base  out  16  slot 2 base A31..A16
eth_base  out  16  slot 3 base A31..A16
z2_cfg, z3a_cfg, z3b_cfg, eth_cfg  out  1 each  slot configured
cfg_done  out  1  chain exhausted

Behaviour:
- Reset (async):
  - State INIT0; slot=0.
  - All bases 0, all *_cfg 0, cfg_done 0, ack 0, dout 16'hFFFF, rom_we 0.
  - Reset mid-operation aborts any pending access with no ack.
- States: INIT0, INIT1, INIT2, SELECT, IDLE, RD1, RD2, RD3, ACK, DONE.
- INIT0: rom_we=1, a_write 'h001, d = size code for fastram_sz (01→0110, 10→0111, 11→0000; 00 writes 1111).
- INIT1: a_write 'h081, d = 0110 (2MB) or 0111 (4MB) from bank0_sz.
- INIT2: a_write 'h085, d = same code as INIT1. Then go to SELECT.
- rom_we is high for exactly these three cycles only.
- A slot is enabled as follows: slot 0 if fastram_sz≠00; slot 1 if z3_en; slot 2 if bank0_sz is 01 or 10; slot 3 if eth_en.
- SELECT (one clock per step): if the current slot is enabled, go to IDLE; else slot+1. When stepping past slot 3, go to DONE.
- IDLE, req=1 and we=0:
  - Register rom_a_read = {1'b0, slot, addr}.
  - Go RD1 → RD2 → RD3. RD3 captures dout = {rom_q, 12'hFFF}.
  - ack=1 in the cycle after RD3, i.e. 4 clocks after the accepting edge.
- IDLE, req=1 and we=1: decode at the accepting edge; ack 1 clock later.
  - Slot 0, addr 'h24 (offset $48): z2_base=din[15:8], z2_cfg=1, advance.
  - Slot 1..3, addr 'h22 (offset $44): matching *_base=din[15:0], *_cfg=1, advance.
  - Any slot, addr 'h26 (offset $4C, shut-up): *_cfg stays 0, advance.
  - All other write offsets (incl. $4A): ack only, no state change.
- Advance: slot+1 and go to SELECT. If slot was 3, go to DONE.
- ACK: ack high one cycle. Hold until req=0 is sampled, then return to IDLE (or SELECT/DONE after an advance). A held req is never serviced twice.
- DONE: cfg_done=1. Reads ack after 1 clock with dout=16'hFFFF. Writes ack with no effect. Stays in DONE until reset.
- req arriving during INIT*/SELECT waits; it is serviced on entry to IDLE or DONE.
- Bases and flags are sticky until reset.

Decomposition:
- Package minimig_autoconfig_pkg:
  - state enum.
  - slot indices SLOT_Z2=0, SLOT_Z3A=1, SLOT_Z3B=2, SLOT_ETH=3.
  - register indices REG_Z3BASE='h22, REG_Z2BASE='h24, REG_SHUTUP='h26.
  - size-code constants.
- No sub-module. The size-code encoder is a package function.

Test Plan:
- fastram_sz=11, bank0_sz=10 → writes 'h001←0000, 'h081←0111, 'h085←0111 in 3 consecutive cycles. Then read offset $02 → dout=16'h0FFF, ack 4 clocks after accept.
- Write $48 din=16'h2000 on slot 0 → z2_base=8'h20, z2_cfg=1. Next read $00 → dout[15:12]=1010 (slot 1).
- Slot 1 shut-up write $4C → z3a_cfg=0, slot 2 active. Write $44 din=16'h4000 → z3b_base=16'h4000, z3b_cfg=1.
- fastram_sz=00, z3_en=0, bank0_sz=00, eth_en=1 → first read $00 returns 1000. Write $44 din=16'h4010 → eth_base=16'h4010, then cfg_done=1 and reads return 16'hFFFF.
- req held high for 10 clocks after ack → exactly one ack. Dropping and reasserting req → second ack.
- Reset asserted in RD2 → ack never pulses, all outputs return to reset values, INIT rewrites occur after release.
